// File: rtl/nand_gate_sweeper.sv
// nand_gate_sweeper: walks a three-input gate cell through all eight ABC
// combinations, holds each vector for SETTLE_CYCLES, then compares the
// cell's Y against the expected NAND3 or NOR3 value and keeps a
// pass/fail report (mismatch count and first failing vector).
module nand_gate_sweeper #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       gate_sel,
  input  logic       dut_y,
  output logic       dut_a,
  output logic       dut_b,
  output logic       dut_c,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_count,
  output logic       first_fail_valid,
  output logic [2:0] first_fail_vec
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_SAMPLE,
    S_DONE
  } state_t;

  // Last settle count before sampling; SETTLE_CYCLES must lie in 1..15.
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  state_t     state_q;
  logic [2:0] vec_q;
  logic [3:0] settle_cnt_q;
  logic       sel_q;
  logic       busy_q;
  logic       done_q;
  logic       pass_q;
  logic [3:0] err_q;
  logic       ffv_q;
  logic [2:0] ffvec_q;

  logic       exp_y;
  logic       mismatch;
  logic       start_ok;
  logic [3:0] err_d;

  // Expected cell output for the vector currently driven, plus the
  // mismatch flag. The 4-state inequality makes an X/Z on Y count as a
  // failure in simulation; synthesis treats it as a plain compare.
  always_comb begin
    exp_y    = sel_q ? ~(|vec_q) : ~(&vec_q);
    mismatch = (dut_y !== exp_y);
    start_ok = start && ((state_q == S_IDLE) || (state_q == S_DONE));
    err_d    = err_q + 4'(mismatch);
  end

  // Sweep controller: vector stepping, settle timing and report registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      vec_q        <= 3'd0;
      settle_cnt_q <= 4'd0;
      sel_q        <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      err_q        <= 4'd0;
      ffv_q        <= 1'b0;
      ffvec_q      <= 3'd0;
    end else if (start_ok) begin
      // A new sweep discards any previous report and latches the function.
      state_q      <= S_SETTLE;
      vec_q        <= 3'd0;
      settle_cnt_q <= 4'd0;
      sel_q        <= gate_sel;
      busy_q       <= 1'b1;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      err_q        <= 4'd0;
      ffv_q        <= 1'b0;
      ffvec_q      <= 3'd0;
    end else begin
      case (state_q)
        S_SETTLE: begin
          if (settle_cnt_q == SETTLE_LAST) begin
            settle_cnt_q <= 4'd0;
            state_q      <= S_SAMPLE;
          end else begin
            settle_cnt_q <= settle_cnt_q + 4'd1;
          end
        end
        S_SAMPLE: begin
          // Y is judged on the edge that applies the next vector.
          err_q <= err_d;
          if (mismatch && !ffv_q) begin
            ffv_q   <= 1'b1;
            ffvec_q <= vec_q;
          end
          if (vec_q == 3'd7) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (err_d == 4'd0);
          end else begin
            vec_q   <= vec_q + 3'd1;
            state_q <= S_SETTLE;
          end
        end
        default: begin
          // IDLE and DONE hold until an accepted start.
          state_q <= state_q;
        end
      endcase
    end
  end

  assign dut_a            = vec_q[2];
  assign dut_b            = vec_q[1];
  assign dut_c            = vec_q[0];
  assign busy             = busy_q;
  assign done             = done_q;
  assign pass             = pass_q;
  assign err_count        = err_q;
  assign first_fail_valid = ffv_q;
  assign first_fail_vec   = ffvec_q;

endmodule

// File: tb/tb_nand_gate_sweeper.sv
// Bench for nand_gate_sweeper: a behavioural gate cell (correct NAND3,
// stuck-at-1, or X on vector 3) sits under the sweeper; each accepted
// sweep pushes its hand-computed report into a queue that a monitor pops
// when done rises.
module tb_nand_gate_sweeper;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       gate_sel;
  logic       dut_y;
  logic       dut_a, dut_b, dut_c;
  logic       busy, done, pass;
  logic [3:0] err_count;
  logic       first_fail_valid;
  logic [2:0] first_fail_vec;

  nand_gate_sweeper #(.SETTLE_CYCLES(2)) dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .gate_sel         (gate_sel),
    .dut_y            (dut_y),
    .dut_a            (dut_a),
    .dut_b            (dut_b),
    .dut_c            (dut_c),
    .busy             (busy),
    .done             (done),
    .pass             (pass),
    .err_count        (err_count),
    .first_fail_valid (first_fail_valid),
    .first_fail_vec   (first_fail_vec)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       pass;
    logic [3:0] err;
    logic       ffv;
    logic [2:0] ffvec;
    int         t0;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   cur_t0 = 0;
  logic live = 1'b0;
  logic done_prev = 1'b0;
  int   mode = 0;
  logic xv;

  always @(posedge clk) cyc <= cyc + 1;

  // Gate cell model: 0 = correct NAND3, 1 = Y stuck at 1, 2 = NAND3 with X on ABC=011.
  always_comb begin
    dut_y = ~(dut_a & dut_b & dut_c);
    if (mode == 1) dut_y = 1'b1;
    else if (mode == 2 && {dut_a, dut_b, dut_c} == 3'd3) dut_y = xv;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at cycle %0d", name, act, req, cyc);
    end
  endtask

  // Monitor: per-cycle busy/ABC tracking while a sweep is live, and report check on done rise.
  always @(posedge clk) begin
    int el;
    exp_t it;
    #1;
    if (!rst) begin
      if (live) begin
        el = cyc - cur_t0;
        check("busy", {31'd0, busy}, (el < 24) ? 32'd1 : 32'd0);
        if (el < 24) check("abc", {29'd0, dut_a, dut_b, dut_c}, el / 3);
      end
      if (done && !done_prev) begin
        check("done_expected", sb.size(), 1);
        if (sb.size() != 0) begin
          it = sb.pop_front();
          check("pass", {31'd0, pass}, {31'd0, it.pass});
          check("err_count", {28'd0, err_count}, {28'd0, it.err});
          check("ff_valid", {31'd0, first_fail_valid}, {31'd0, it.ffv});
          check("ff_vec", {29'd0, first_fail_vec}, {29'd0, it.ffvec});
          check("latency", cyc - it.t0, 24);
        end
      end
    end
    done_prev = done;
  end

  task automatic wait_until(input int target);
    for (int i = 0; i < 200 && cyc < target; i++) @(negedge clk);
  endtask

  task automatic sweep(input logic sel, input logic e_pass, input logic [3:0] e_err,
                       input logic e_ffv, input logic [2:0] e_ffvec);
    exp_t it;
    @(negedge clk);
    live     = 1'b0;
    start    = 1'b1;
    gate_sel = sel;
    @(negedge clk);
    start    = 1'b0;
    gate_sel = 1'b0;
    cur_t0   = cyc;
    live     = 1'b1;
    check("accept_done_low", {31'd0, done}, 0);
    check("accept_busy_high", {31'd0, busy}, 1);
    it.pass = e_pass; it.err = e_err; it.ffv = e_ffv; it.ffvec = e_ffvec; it.t0 = cur_t0;
    sb.push_back(it);
  endtask

  task automatic drain();
    for (int i = 0; i < 80 && sb.size() != 0; i++) @(negedge clk);
    check("drain", sb.size(), 0);
  endtask

  function automatic logic [13:0] outs();
    return {dut_a, dut_b, dut_c, busy, done, pass, err_count, first_fail_valid, first_fail_vec};
  endfunction

  initial begin
    xv       = 1'bx;
    rst      = 1'b1;
    start    = 1'b0;
    gate_sel = 1'b0;
    #1;
    check("reset_outputs", {18'd0, outs()}, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_outputs", {18'd0, outs()}, 0);

    // Correct NAND3, NAND expected: clean pass.
    mode = 0;
    sweep(1'b0, 1'b1, 4'd0, 1'b0, 3'd0);
    drain();

    // Y stuck at 1: only ABC=111 fails.
    mode = 1;
    sweep(1'b0, 1'b0, 4'd1, 1'b1, 3'd7);
    drain();

    // Correct NAND3 judged as NOR3: vectors 1..6 fail.
    mode = 0;
    sweep(1'b1, 1'b0, 4'd6, 1'b1, 3'd1);
    drain();

    // X on vector 3. A 2-state simulator resolves X to a fixed level; a 1 would match.
    mode = 2;
    if ($isunknown(xv) || xv !== 1'b1) sweep(1'b0, 1'b0, 4'd1, 1'b1, 3'd3);
    else                              sweep(1'b0, 1'b1, 4'd0, 1'b0, 3'd0);
    drain();
    mode = 0;

    // Asynchronous reset mid-sweep, then a clean sweep.
    sweep(1'b1, 1'b0, 4'd6, 1'b1, 3'd1);
    wait_until(cur_t0 + 10);
    live = 1'b0;
    rst  = 1'b1;
    #1;
    check("midsweep_reset", {18'd0, outs()}, 0);
    void'(sb.pop_back());
    @(negedge clk);
    rst = 1'b0;
    sweep(1'b0, 1'b1, 4'd0, 1'b0, 3'd0);
    drain();

    // Start with a different function while busy must be ignored.
    sweep(1'b0, 1'b1, 4'd0, 1'b0, 3'd0);
    wait_until(cur_t0 + 5);
    start    = 1'b1;
    gate_sel = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    gate_sel = 1'b0;
    drain();
    check("done_held", {31'd0, done}, 1);

    // Start accepted from DONE clears done and runs the new function.
    sweep(1'b1, 1'b0, 4'd6, 1'b1, 3'd1);
    drain();

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/nand_gate_sweeper.md
# nand_gate_sweeper

Synchronous exhaustive stimulus-and-check stage for the three-input gate cells in `nand_nor_gates`. It sits directly around the switch-level gate under test:
- upstream, it drives the gate's A, B and C inputs through all eight combinations;
- downstream, it consumes the gate's Y output.

After each vector has settled, it compares Y against the expected NAND3 or NOR3 truth value and accumulates a pass/fail report.

## Interface
- `SETTLE_CYCLES`, default 2: clock cycles each vector is held before Y is sampled. Legal range is 1..15; 0 is illegal.
- `clk` input 1: single clock, rising-edge.
- `rst` input 1: asynchronous, active-high reset.
- `start` input 1: single-cycle request to begin a sweep. Accepted only in IDLE or DONE.
- `gate_sel` input 1: expected function. 0 = NAND3, 1 = NOR3. Latched when `start` is accepted.
- `dut_y` input 1: Y output of the gate under test.
- `dut_a` output 1: drives A of the gate under test; equals `vec[2]`.
- `dut_b` output 1: drives B of the gate under test; equals `vec[1]`.
- `dut_c` output 1: drives C of the gate under test; equals `vec[0]`.
- `busy` output 1: high while a sweep is in progress.
- `done` output 1: high in DONE; held until the next accepted `start` or `rst`.
- `pass` output 1: valid when `done` is high; 1 iff `err_count` == 0.
- `err_count` output 4: number of mismatching vectors, 0..8.
- `first_fail_valid` output 1: at least one mismatch recorded.
- `first_fail_vec` output 3: lowest vector index that mismatched.

## Operation
- Reset value of every output, and of the internal registers `vec`, `settle_cnt` and `sel_q`, is 0. State resets to IDLE.
- State machine has four states: IDLE, SETTLE, SAMPLE, DONE.
- IDLE:
  - `start` high → `vec` = 0, `settle_cnt` = 0, `sel_q` = `gate_sel`, `err_count` = 0, `first_fail_valid` = 0, `first_fail_vec` = 0. Next state SETTLE.
  - `start` low → stay in IDLE.
- SETTLE: `settle_cnt` increments each cycle. When `settle_cnt` == `SETTLE_CYCLES`-1, clear `settle_cnt` and go to SAMPLE.
- SAMPLE: the clock edge that leaves SAMPLE registers the comparison of `dut_y` against the expected value for the current `vec`.
  - Expected value: NAND3 = ~(a&b&c); NOR3 = ~(a|b|c).
  - On mismatch, `err_count`++. If `first_fail_valid` is 0, set `first_fail_valid` = 1 and `first_fail_vec` = `vec`.
  - If `vec` == 7, go to DONE and leave `vec` at 7.
  - Otherwise `vec`++ and go back to SETTLE.
- DONE: `done` = 1, `busy` = 0, `pass` = (`err_count` == 0). Results are held. An accepted `start` restarts exactly as from IDLE and clears `done` on that edge.
- `start` while `busy` is ignored; `gate_sel` changes while `busy` are also ignored.
- In simulation, `dut_y` equal to X or Z counts as a mismatch (4-state inequality compare).
- `err_count` cannot exceed 8, so no saturation logic is needed.
- `rst` asserted mid-sweep returns the block immediately (asynchronously) to the reset values above. No partial report is retained.
- `dut_a`, `dut_b` and `dut_c` come from registers, so they are glitch-free and never combinationally derived from `start`.

## Timing
- `start` accepted at edge t0. From t0, `busy` = 1 and `dut_a`/`dut_b`/`dut_c` = 000.
- Let P = `SETTLE_CYCLES`+1 (cycles per vector).
- Vector k is driven from edge t0+k·P to edge t0+(k+1)·P.
- `dut_y` for vector k is sampled at edge t0+(k+1)·P, the same edge on which the next vector is applied.
- `done` rises and `busy` falls at edge t0+8·P. With the default `SETTLE_CYCLES` = 2, this is t0+24.
- `err_count` and `first_fail_*` update on the sample edge of the failing vector. They are stable, and `pass` is valid, from the `done` edge onward.
- Sweep time from `start` to `done` = 8·(`SETTLE_CYCLES`+1) cycles. There is no additional pipeline latency.

## Test plan
- Correct NAND3 model, `gate_sel` = 0, `SETTLE_CYCLES` = 2, `start` at t0 → `done` at t0+24, `pass` = 1, `err_count` = 0, `first_fail_valid` = 0; ABC steps 000→111 every 3 cycles.
- NAND3 model with Y stuck at 1, `gate_sel` = 0 → `err_count` = 1, `first_fail_vec` = 7, `pass` = 0.
- Correct NAND3 model, `gate_sel` = 1 (NOR expected) → mismatches at vectors 1..6 → `err_count` = 6, `first_fail_vec` = 1.
- `rst` pulsed at t0+10 mid-sweep → all outputs 0 and state IDLE immediately. A new `start` then completes normally in 24 cycles.
- `start` re-asserted at t0+5 with `gate_sel` toggled → ignored; `done` still at t0+24 with the original function. `start` in DONE → `done` clears and a new sweep begins.
- `dut_y` = X for vector 3 only, with a NAND3 model otherwise correct → `err_count` = 1, `first_fail_vec` = 3.
